// File: rtl/mul_sched_pkg.sv
// Shared constants for the multiplier scheduler.
// State encodings, default parameters and a clog2 helper.
package mul_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_sched_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (levels), ptr (last grant) -> valid, idx (next grant).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] k;

  // Walk from the farthest offset to the nearest so the
  // nearest set bit after ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % NREQ);
      if (req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin front end sharing one go/done sequential multiplier.
// Ports: req/a_in/b_in in, ack/err/result out, mul_* to multiplier.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [2*WIDTH-1:0]    result,
  output logic                  busy,
  output logic [clog2(NREQ)-1:0] grant_id,
  output logic                  mul_go,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_p
);

  localparam int IW = clog2(NREQ);
  localparam int WW = clog2(TIMEOUT);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [IW-1:0] rr_ptr;
  logic [WW-1:0] wd;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          done_ok;
  logic          wd_exp;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // wd==0 is the first RUN cycle; done there may be stale.
  assign done_ok = mul_done && (wd != '0);
  assign wd_exp  = (wd == WW'(TIMEOUT - 1));
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (pick_valid) state_n = S_LOAD;
      S_LOAD: state_n = S_RUN;
      S_RUN:  if (done_ok || wd_exp) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // mul_go is a register so it is glitch-free and drops
  // asynchronously with reset, clearing the multiplier too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mul_go   <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      result   <= '0;
      grant_id <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      wd       <= '0;
      rr_ptr   <= IW'(NREQ - 1);
    end else begin
      state  <= state_n;
      mul_go <= (state_n == S_RUN);
      ack    <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            rr_ptr   <= pick_idx;
            mul_a    <= a_in[int'(pick_idx)*WIDTH +: WIDTH];
            mul_b    <= b_in[int'(pick_idx)*WIDTH +: WIDTH];
          end
        end
        S_LOAD: wd <= '0;
        S_RUN: begin
          wd <= wd + WW'(1);
          if (done_ok) begin
            result <= mul_p;
            err    <= 1'b0;
            ack    <= NREQ'(1) << grant_id;
          end else if (wd_exp) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= NREQ'(1) << grant_id;
          end
        end
        S_RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a scoreboard of acks.
// Includes a behavioral go/done multiplier model.
module tb_mul_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        e;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    req;
  logic [31:0]   a_in;
  logic [31:0]   b_in;
  logic [3:0]    ack;
  logic          err;
  logic [15:0]   result;
  logic          busy;
  logic [1:0]    grant_id;
  logic          mul_go;
  logic [7:0]    mul_a;
  logic [7:0]    mul_b;
  logic          mul_done;
  logic [15:0]   mul_p;

  logic force_done;
  logic never;
  int   lat;
  int   mcnt;
  int   total = 0;
  int   bad = 0;
  int   cyc;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_scheduler #(.NREQ(4), .WIDTH(8), .TIMEOUT(64)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .ack      (ack),
    .err      (err),
    .result   (result),
    .busy     (busy),
    .grant_id (grant_id),
    .mul_go   (mul_go),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_done (mul_done),
    .mul_p    (mul_p)
  );

  // Multiplier model: done after lat cycles of go=1.
  always @(posedge clk) begin
    if (!mul_go) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end
  assign mul_done = force_done |
                    (!never && mul_go && (mcnt >= lat));
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*W +: W] = 8'(a);
    b_in[i*W +: W] = 8'(b);
  endtask

  task automatic push(input int id, input int res, input bit e);
    exp_t x;
    x.id  = id;
    x.res = 16'(res);
    x.e   = e;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input int maxc, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (ack != 4'b0) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // Scoreboard checker on the falling edge.
  always @(negedge clk) begin
    if (ack != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(4'b1 << x.id));
        chk("sb_result", 32'(result), 32'(x.res));
        chk("sb_err", 32'(err), 32'(x.e));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    req        = '0;
    a_in       = '0;
    b_in       = '0;
    force_done = 1'b0;
    never      = 1'b0;
    lat        = 9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_go", 32'(mul_go), 32'd0);
    chk("rst_a", 32'(mul_a), 32'd0);
    chk("rst_b", 32'(mul_b), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single job, done 9 RUN cycles after go.
    set_ops(0, 13, 11);
    req = 4'b0001;
    push(0, 143, 1'b0);
    wait_ack(100, cyc);
    chk("single_latency", 32'(cyc), 32'd12);
    req = 4'b0000;
    chk("go_low_resp", 32'(mul_go), 32'd0);
    @(posedge clk);
    #1;
    chk("go_low_idle", 32'(mul_go), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);

    // Request dropped right after grant.
    set_ops(1, 255, 255);
    req = 4'b0010;
    push(1, 65025, 1'b0);
    @(posedge clk);
    #1;
    req = 4'b0000;
    chk("drop_busy", 32'(busy), 32'd1);
    chk("drop_grant", 32'(grant_id), 32'd1);
    wait_ack(100, cyc);
    @(posedge clk);
    #1;

    // Watchdog abort, then a normal job.
    never = 1'b1;
    set_ops(0, 200, 3);
    req = 4'b0001;
    push(0, 0, 1'b1);
    wait_ack(100, cyc);
    chk("wd_latency", 32'(cyc), 32'd66);
    req   = 4'b0000;
    never = 1'b0;
    @(posedge clk);
    #1;
    set_ops(3, 7, 9);
    req = 4'b1000;
    push(3, 63, 1'b0);
    wait_ack(100, cyc);
    chk("after_wd_latency", 32'(cyc), 32'd12);
    req = 4'b0000;
    @(posedge clk);
    #1;

    // Stale done through LOAD and RUN0, real pulse at wd=5.
    never      = 1'b1;
    force_done = 1'b1;
    set_ops(2, 3, 4);
    req = 4'b0100;
    push(2, 12, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) force_done = 1'b0;
      if (k == 7) force_done = 1'b1;
      if (k == 8) force_done = 1'b0;
      if (k < 8) chk("stale_noack", 32'(ack), 32'd0);
      else chk("stale_ack", 32'(ack), 32'b0100);
    end
    req   = 4'b0000;
    never = 1'b0;
    @(posedge clk);
    #1;

    // Reset in RUN wd=3.
    set_ops(0, 5, 5);
    req = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_go", 32'(mul_go), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_go", 32'(mul_go), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_ops(0, 6, 7);
    set_ops(2, 9, 10);
    req = 4'b0101;
    push(0, 42, 1'b0);
    push(2, 90, 1'b0);
    wait_ack(100, cyc);
    req = 4'b0100;
    wait_ack(100, cyc);
    req = 4'b0000;
    @(posedge clk);
    #1;

    // Fairness with all requests held.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    lat = 3;
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, 16 + i);
    req = 4'b1111;
    push(0, 16, 1'b0);
    push(1, 34, 1'b0);
    push(2, 54, 1'b0);
    push(3, 76, 1'b0);
    push(0, 16, 1'b0);
    for (int j = 0; j < 5; j++) wait_ack(100, cyc);
    req = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
